div_iter_radix2: RTL and testbench
==================================

Name: div_iter_radix2

Overview:
- Iterative radix-2 restoring divider for the LoongArch execute stage.
- Consumed by the MDU for DIV/MOD/DIVU/MODU; replaces the vendor divider IP.
- Takes operands on a valid/ready input port and returns quotient and remainder together on a valid/ready output port.
- Performs one quotient bit per cycle.

Parameters:
- DATA_WIDTH, 32, operand/result width; must be even and at least 4.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous active-high reset.
- in_valid  input  1  operands offered.
- in_ready  output  1  divider can accept (IDLE only).
- in_signed  input  1  1 = signed (DIV/MOD), 0 = unsigned (DIVU/MODU).
- in_dividend  input  DATA_WIDTH  dividend A.
- in_divisor  input  DATA_WIDTH  divisor B.
- out_valid  output  1  result available.
- out_ready  input  1  consumer takes result.
- out_quotient  output  DATA_WIDTH  quotient.
- out_remainder  output  DATA_WIDTH  remainder.

Behaviour:
- Clock and reset: one clock, clk; rst synchronous, active-high. rst forces IDLE, out_valid=0, out_quotient=0, out_remainder=0, internal regs 0. rst mid-operation aborts silently: no out_valid, in_ready=1 the cycle after rst deasserts.
- States: IDLE, CALC, DONE (one-hot, 3 bits). in_ready = state==IDLE (registered-state decode, no combinational path from in_valid).
- Accept (IDLE, in_valid && in_ready):
  - Latch |A|, |B| (two's-complement negate when in_signed and sign bit set; 0x80000000 magnitude is 0x80000000 unsigned).
  - Latch sign_q = in_signed & (A[msb]^B[msb]), sign_r = in_signed & A[msb], div0 = (B==0), original A.
  - rem=0, quo=|A|, count=DATA_WIDTH-1; go CALC. Operand changes after accept are ignored.
- CALC, each cycle:
  - trial = {rem[W-2:0],quo[W-1]} - |B| at W+1 bits.
  - No borrow: rem=trial, quo={quo[W-2:0],1}. Borrow: rem={rem[W-2:0],quo[W-1]}, quo={quo[W-2:0],0}.
  - count decrements. At count==0 the iteration completes and the state goes to DONE, with outputs registered in the same edge:
    - div0: quotient = all ones, remainder = original A (sign flags ignored).
    - Otherwise: quotient = sign_q ? -quo : quo; remainder = sign_r ? -rem : rem.
- Latency: out_valid rises exactly DATA_WIDTH+1 edges after the accept edge (33 for W=32).
- DONE:
  - out_valid=1; outputs held stable while out_ready=0.
  - On out_valid && out_ready, go IDLE; out_valid=0 next cycle.
  - in_ready stays 0 in DONE, so back-to-back ops start no sooner than one cycle after the output handshake.
- Signed overflow: 0x80000000 / -1 gives quotient 0x80000000, remainder 0 (falls out of the algorithm, no special case).
- Remainder sign always equals dividend sign; |remainder| < |divisor| when divisor≠0.

Optional Feature:
- Macro DIV_ITER_EARLY_OUT_EN.
- Defined: at accept, if div0 or |A| < |B|, skip CALC; go directly to DONE next edge with:
  - div0: quotient = all ones, remainder = A.
  - |A| < |B|: quotient 0, remainder = A.
  - Latency 1 in these cases, DATA_WIDTH+1 otherwise.
- Undefined: latency fixed at DATA_WIDTH+1 for all operands; results identical in both builds.

Decomposition:
- Package div_pkg holds:
  - state encoding localparams (S_IDLE, S_CALC, S_DONE bit indices);
  - the default DATA_WIDTH constant;
  - the counter width function clog2(DATA_WIDTH).
- One natural sub-module, div_iter_step: combinational single-iteration trial subtract and shift (rem, quo, divisor in; next rem, next quo out). Instantiated once.

Test Plan:
- Unsigned 7/2, in_signed=0 -> out_valid at edge 33 after accept, q=0x00000003, r=0x00000001.
- Signed -7/2 (0xFFFFFFF9/0x2) -> q=0xFFFFFFFD, r=0xFFFFFFFF; also 7/-2 -> q=0xFFFFFFFD, r=0x00000001.
- Corner cases:
  - Signed 0x80000000/0xFFFFFFFF -> q=0x80000000, r=0.
  - Unsigned 0xFFFFFFFF/1 -> q=0xFFFFFFFF, r=0.
- Divide by zero:
  - 5/0 signed and unsigned -> q=0xFFFFFFFF, r=0x5.
  - -5/0 signed -> q=0xFFFFFFFF, r=0xFFFFFFFB.
  - With DIV_ITER_EARLY_OUT_EN, out_valid one edge after accept.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> outputs and out_valid stable, in_ready=0; raise out_ready -> IDLE next cycle; a new op is accepted the cycle after.
- Reset mid-op: assert rst 10 cycles after accept -> out_valid never rises, outputs 0, in_ready=1 after rst drops; the following 100/7 yields q=14, r=2.

Source files
------------

// File: rtl/div_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : div_pkg
// Description : Shared definitions for the iterative radix-2 divider.
//               - One-hot state bit indices and the state enum built on them
//               - Default operand width
//               - Counter width helper clog2()
// Revision    : 1.0 - initial release
// ============================================================================
package div_pkg;

  // Bit positions inside the one-hot state vector
  localparam int S_IDLE = 0;
  localparam int S_CALC = 1;
  localparam int S_DONE = 2;

  localparam int DEFAULT_DATA_WIDTH = 32;

  typedef enum logic [2:0] {
    ST_IDLE = 3'(1 << S_IDLE),
    ST_CALC = 3'(1 << S_CALC),
    ST_DONE = 3'(1 << S_DONE)
  } state_t;

  // Ceiling log2; sizes the iteration counter (holds DATA_WIDTH-1 down to 0)
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v      = value - 1;
    while (v > 0) begin
      result = result + 1;
      v      = v >> 1;
    end
    return result;
  endfunction

endpackage : div_pkg
`default_nettype wire

// File: rtl/div_iter_step.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : div_iter_step
// Description : Combinational single iteration of a restoring divider.
//               Shifts the next dividend bit into the partial remainder,
//               trial-subtracts the divisor and produces one quotient bit.
// Ports       : rem      - current partial remainder
//               quo      - dividend/quotient shift register (MSB feeds rem)
//               divisor  - divisor magnitude
//               next_rem - partial remainder after this step
//               next_quo - shift register with the new quotient bit in LSB
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter_step
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic [DATA_WIDTH-1:0] rem,
  input  logic [DATA_WIDTH-1:0] quo,
  input  logic [DATA_WIDTH-1:0] divisor,
  output logic [DATA_WIDTH-1:0] next_rem,
  output logic [DATA_WIDTH-1:0] next_quo
);

  // The shifted partial remainder keeps rem's MSB (W+1 bits) so that
  // unsigned divisors above 2^(W-1) are still handled exactly; the extra
  // top bit of the difference is the borrow.
  logic [DATA_WIDTH:0]   w_partial;
  logic [DATA_WIDTH+1:0] w_diff;
  logic                  w_borrow;
  logic                  w_unused_diff_bit;

  assign w_partial = {rem, quo[DATA_WIDTH-1]};
  assign w_diff    = {1'b0, w_partial} - {2'b00, divisor};
  assign w_borrow  = w_diff[DATA_WIDTH+1];

  // A successful subtraction always leaves a value below the divisor,
  // so bit DATA_WIDTH of the difference is zero whenever it is used.
  assign w_unused_diff_bit = w_diff[DATA_WIDTH];

  assign next_rem = w_borrow ? w_partial[DATA_WIDTH-1:0] : w_diff[DATA_WIDTH-1:0];
  assign next_quo = {quo[DATA_WIDTH-2:0], ~w_borrow};

endmodule : div_iter_step
`default_nettype wire

// File: rtl/div_iter_radix2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : div_iter_radix2
// Description : Iterative radix-2 restoring divider, one quotient bit per
//               cycle, signed or unsigned. Returns quotient and remainder
//               together. Divide by zero yields all-ones quotient and the
//               original dividend as remainder.
// Ports       : clk, rst (sync, active high)
//               in_valid/in_ready, in_signed, in_dividend, in_divisor
//               out_valid/out_ready, out_quotient, out_remainder
// Config      : DIV_ITER_EARLY_OUT_EN - when defined, divide-by-zero and
//               |A| < |B| skip the iterations and complete in one cycle.
// Params      : DATA_WIDTH - operand width, even and >= 4.
// Revision    : 1.0 - initial release
// ============================================================================
module div_iter_radix2
  import div_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic                  in_signed,
  input  logic [DATA_WIDTH-1:0] in_dividend,
  input  logic [DATA_WIDTH-1:0] in_divisor,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_quotient,
  output logic [DATA_WIDTH-1:0] out_remainder
);

  localparam int CNT_W = clog2(DATA_WIDTH);

  state_t                r_state;
  state_t                w_state_next;

  logic [DATA_WIDTH-1:0] r_rem;
  logic [DATA_WIDTH-1:0] r_quo;
  logic [DATA_WIDTH-1:0] r_abs_b;
  logic [DATA_WIDTH-1:0] r_dividend;
  logic [CNT_W-1:0]      r_count;
  logic                  r_sign_q;
  logic                  r_sign_r;
  logic                  r_div0;
  logic [DATA_WIDTH-1:0] r_quotient;
  logic [DATA_WIDTH-1:0] r_remainder;

  logic                  w_a_neg;
  logic                  w_b_neg;
  logic [DATA_WIDTH-1:0] w_abs_a;
  logic [DATA_WIDTH-1:0] w_abs_b;
  logic                  w_div0_in;
  logic                  w_early;
  logic                  w_accept;
  logic                  w_last;
  logic [DATA_WIDTH-1:0] w_next_rem;
  logic [DATA_WIDTH-1:0] w_next_quo;

  // --------------------------------------------------------------------------
  // Operand conditioning at accept. The most negative value negates to
  // itself, which read as unsigned is exactly its magnitude.
  // --------------------------------------------------------------------------
  assign w_a_neg   = in_signed & in_dividend[DATA_WIDTH-1];
  assign w_b_neg   = in_signed & in_divisor[DATA_WIDTH-1];
  assign w_abs_a   = w_a_neg ? -in_dividend : in_dividend;
  assign w_abs_b   = w_b_neg ? -in_divisor  : in_divisor;
  assign w_div0_in = (in_divisor == '0);
  assign w_accept  = in_valid && (r_state == ST_IDLE);
  assign w_last    = (r_count == '0);

`ifdef DIV_ITER_EARLY_OUT_EN
  // Quotient is trivially all-ones (div0) or zero (|A| < |B|); in both
  // cases the remainder is the dividend unchanged.
  assign w_early = w_div0_in | (w_abs_a < w_abs_b);
`else
  assign w_early = 1'b0;
`endif

  div_iter_step #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_step (
    .rem      (r_rem),
    .quo      (r_quo),
    .divisor  (r_abs_b),
    .next_rem (w_next_rem),
    .next_quo (w_next_quo)
  );

  // --------------------------------------------------------------------------
  // State machine
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (in_valid) begin
          w_state_next = w_early ? ST_DONE : ST_CALC;
        end
      end
      ST_CALC: begin
        if (w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // Both handshake outputs decode the registered state only
  assign in_ready  = (r_state == ST_IDLE);
  assign out_valid = (r_state == ST_DONE);

  // --------------------------------------------------------------------------
  // Datapath
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rem       <= '0;
      r_quo       <= '0;
      r_abs_b     <= '0;
      r_dividend  <= '0;
      r_count     <= '0;
      r_sign_q    <= 1'b0;
      r_sign_r    <= 1'b0;
      r_div0      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
    end else begin
      if (w_accept) begin
        r_rem      <= '0;
        r_quo      <= w_abs_a;
        r_abs_b    <= w_abs_b;
        r_dividend <= in_dividend;
        r_count    <= CNT_W'(DATA_WIDTH - 1);
        r_sign_q   <= w_a_neg ^ w_b_neg;
        r_sign_r   <= w_a_neg;
        r_div0     <= w_div0_in;
        if (w_early) begin
          r_quotient  <= w_div0_in ? '1 : '0;
          r_remainder <= in_dividend;
        end
      end else if (r_state == ST_CALC) begin
        r_rem   <= w_next_rem;
        r_quo   <= w_next_quo;
        r_count <= r_count - 1'b1;
        if (w_last) begin
          // Final step: fold the sign correction into the result registers
          if (r_div0) begin
            r_quotient  <= '1;
            r_remainder <= r_dividend;
          end else begin
            r_quotient  <= r_sign_q ? -w_next_quo : w_next_quo;
            r_remainder <= r_sign_r ? -w_next_rem : w_next_rem;
          end
        end
      end
    end
  end

  assign out_quotient  = r_quotient;
  assign out_remainder = r_remainder;

endmodule : div_iter_radix2
`default_nettype wire

// File: tb/tb_div_iter_radix2.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_div_iter_radix2
// Description : Self-checking bench for div_iter_radix2 (DATA_WIDTH=32).
//               Directed vectors push expected quotient/remainder/latency
//               into a queue; a monitor compares on each output handshake.
//               Honours DIV_ITER_EARLY_OUT_EN for short-path latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_div_iter_radix2;

  localparam int W        = 32;
  localparam int LAT_FULL = W + 1;
`ifdef DIV_ITER_EARLY_OUT_EN
  localparam int LAT_SHORT = 1;
`else
  localparam int LAT_SHORT = W + 1;
`endif

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_signed = 1'b0;
  logic [W-1:0] in_dividend = '0;
  logic [W-1:0] in_divisor = '0;
  logic         out_ready = 1'b1;
  logic         in_ready;
  logic         out_valid;
  logic [W-1:0] out_quotient;
  logic [W-1:0] out_remainder;

  div_iter_radix2 #(.DATA_WIDTH(W)) dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_signed     (in_signed),
    .in_dividend   (in_dividend),
    .in_divisor    (in_divisor),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_quotient  (out_quotient),
    .out_remainder (out_remainder)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] q;
    logic [W-1:0] r;
    int           lat;
    int           id;
  } exp_t;

  exp_t         exp_queue[$];
  int           n_checks = 0;
  int           n_fail = 0;
  int           cyc = 0;
  int           acc_cyc = 0;
  bit           seen_valid = 1'b0;
  logic [W-1:0] hold_q;
  logic [W-1:0] hold_r;

  task automatic chk(input string name, input int id, input logic [W-1:0] got,
                     input logic [W-1:0] want);
    n_checks++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s (op %0d): got 0x%h, expected 0x%h", name, id, got, want);
    end
  endtask

  task automatic timeout_fail(input string name, input int id);
    n_checks++;
    n_fail++;
    $display("FAIL %s (op %0d): got timeout, expected event within bound", name, id);
  endtask

  // --------------------------------------------------------------------------
  // Monitor: samples on the falling edge, away from the active edge
  // --------------------------------------------------------------------------
  always @(negedge clk) begin : monitor
    exp_t e;
    cyc++;
    if (rst) begin
      seen_valid = 1'b0;
    end else begin
      if (in_valid && in_ready) acc_cyc = cyc;
      if (out_valid) begin
        if (exp_queue.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_out_valid: got out_valid=1, expected 0 with no op pending");
        end else begin
          e = exp_queue[0];
          if (!seen_valid) begin
            seen_valid = 1'b1;
            hold_q     = out_quotient;
            hold_r     = out_remainder;
            chk("latency", e.id, W'(cyc - acc_cyc), W'(e.lat));
          end else begin
            chk("held_quotient", e.id, out_quotient, hold_q);
            chk("held_remainder", e.id, out_remainder, hold_r);
            chk("in_ready_in_done", e.id, W'(in_ready), W'(0));
          end
          if (out_ready) begin
            void'(exp_queue.pop_front());
            chk("quotient", e.id, out_quotient, e.q);
            chk("remainder", e.id, out_remainder, e.r);
            seen_valid = 1'b0;
          end
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Driver helpers (inputs change 1 time unit after the rising edge)
  // --------------------------------------------------------------------------
  task automatic wait_ready(input int id, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
    end
    if (!ok) timeout_fail("wait_in_ready", id);
  endtask

  task automatic run_op(input int id, input logic sgn, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] exp_q,
                        input logic [W-1:0] exp_r, input int lat, input int hold);
    bit ok;
    wait_ready(id, ok);
    if (!ok) return;
    exp_queue.push_back('{q: exp_q, r: exp_r, lat: lat, id: id});
    in_signed   = sgn;
    in_dividend = a;
    in_divisor  = b;
    in_valid    = 1'b1;
    out_ready   = (hold == 0);
    @(posedge clk); #1;
    // Scramble operands after accept; the result must not depend on them
    in_valid    = 1'b0;
    in_dividend = $urandom;
    in_divisor  = $urandom;
    in_signed   = 1'($urandom_range(0, 1));
    if (hold > 0) begin
      ok = 1'b0;
      for (int i = 0; i < 100; i++) begin
        if (out_valid) begin
          ok = 1'b1;
          break;
        end
        @(posedge clk); #1;
      end
      if (!ok) timeout_fail("wait_out_valid", id);
      repeat (hold) begin
        @(posedge clk); #1;
      end
      out_ready = 1'b1;
    end
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk); #1;
      if (exp_queue.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      timeout_fail("wait_result", id);
      exp_queue.delete();
    end else begin
      chk("out_valid_after_handshake", id, W'(out_valid), W'(0));
      chk("in_ready_after_handshake", id, W'(in_ready), W'(1));
    end
  endtask

  // --------------------------------------------------------------------------
  // Stimulus
  // --------------------------------------------------------------------------
  initial begin : stimulus
    bit ok;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_in_ready", 0, W'(in_ready), W'(1));
    chk("reset_out_valid", 0, W'(out_valid), W'(0));
    chk("reset_quotient", 0, out_quotient, '0);
    chk("reset_remainder", 0, out_remainder, '0);
    rst = 1'b0;
    @(posedge clk); #1;

    //     id sgn dividend      divisor       quotient      remainder     latency    hold
    run_op( 1, 0, 32'h00000007, 32'h00000002, 32'h00000003, 32'h00000001, LAT_FULL,  0);
    run_op( 2, 1, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 32'hFFFFFFFF, LAT_FULL,  0);
    run_op( 3, 1, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000001, LAT_FULL,  0);
    run_op( 4, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h00000000, LAT_FULL,  0);
    run_op( 5, 0, 32'hFFFFFFFF, 32'h00000001, 32'hFFFFFFFF, 32'h00000000, LAT_FULL,  0);
    run_op( 6, 1, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'h00000005, LAT_SHORT, 0);
    run_op( 7, 0, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 32'h00000005, LAT_SHORT, 0);
    run_op( 8, 1, 32'hFFFFFFFB, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFB, LAT_SHORT, 0);
    run_op( 9, 0, 32'h00000003, 32'h0000000A, 32'h00000000, 32'h00000003, LAT_SHORT, 0);
    run_op(10, 1, 32'hFFFFFFFD, 32'h0000000A, 32'h00000000, 32'hFFFFFFFD, LAT_SHORT, 0);
    run_op(11, 0, 32'hFFFFFFFF, 32'h80000001, 32'h00000001, 32'h7FFFFFFE, LAT_FULL,  0);
    run_op(12, 1, 32'h00000064, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'h00000002, LAT_FULL,  0);
    // Backpressure: result held 10 cycles, then an immediate follow-up op
    run_op(13, 0, 32'h00000064, 32'h00000007, 32'h0000000E, 32'h00000002, LAT_FULL, 10);
    run_op(14, 1, 32'hFFFFFF9C, 32'h00000007, 32'hFFFFFFF2, 32'hFFFFFFFE, LAT_FULL,  0);

    // Reset in the middle of an operation: no result may ever appear
    wait_ready(15, ok);
    if (ok) begin
      in_signed   = 1'b0;
      in_dividend = 32'd1000;
      in_divisor  = 32'd3;
      in_valid    = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (10) begin
        @(posedge clk); #1;
      end
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("abort_in_ready", 15, W'(in_ready), W'(1));
      chk("abort_out_valid", 15, W'(out_valid), W'(0));
      chk("abort_quotient", 15, out_quotient, '0);
      chk("abort_remainder", 15, out_remainder, '0);
      repeat (40) begin
        @(posedge clk); #1;
        if (out_valid) begin
          timeout_fail("abort_no_result", 15);
          break;
        end
      end
    end
    run_op(16, 0, 32'd100, 32'd7, 32'd14, 32'd2, LAT_FULL, 0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: got simulation time limit, expected end of test");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_div_iter_radix2
`default_nettype wire
